// File: rtl/db_arbiter.sv
// Pointer, occupancy and direction controller for the shared 64-entry USB data buffer.
// Arbitrates AHB/RX/TX store and get requests into registered one-cycle storage strobes.
module db_arbiter #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          store_tx_data,
  input  logic          store_rx_data,
  input  logic          get_tx_data,
  input  logic          get_rx_data,
  input  logic          clear,
  input  logic          flush,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic [AW:0]   buffer_occupancy,
  output logic [1:0]    mode,
  output logic          overflow,
  output logic          underflow,
  output logic          dir_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TX   = 2'd1,
    RX   = 2'd2
  } mode_t;

  localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FULL_OCC = {1'b1, {AW{1'b0}}};

  mode_t       state_q, state_d;
  logic [AW:0] wptr_q, rptr_q, wptr_d, rptr_d;
  logic [AW:0] occ, occ_d;
  logic        full, empty;
  logic        legal_wr, legal_rd;
  logic        wr_acc, rd_acc;
  logic        ovf_d, unf_d, dir_d;
  logic        kill;

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    legal_wr = 1'b0;
    legal_rd = 1'b0;
    dir_d    = 1'b0;
    occ      = wptr_q - rptr_q;
    full     = (occ == FULL_OCC);
    empty    = (occ == '0);
    kill     = clear | flush;

    // Which requests belong to the current direction; the rest are direction errors.
    case (state_q)
      TX: begin
        legal_wr = store_tx_data;
        legal_rd = get_tx_data;
        dir_d    = store_rx_data | get_rx_data;
      end
      RX: begin
        legal_wr = store_rx_data;
        legal_rd = get_rx_data;
        dir_d    = store_tx_data | get_tx_data;
      end
      default: begin
        legal_wr = store_tx_data | store_rx_data;
        legal_rd = get_tx_data | get_rx_data;
        dir_d    = store_tx_data & store_rx_data;
      end
    endcase

    wr_acc = legal_wr & ~full;
    rd_acc = legal_rd & ~empty;
    ovf_d  = legal_wr & full;
    unf_d  = legal_rd & empty;

    if (wr_acc) wptr_d = wptr_q + ONE;
    if (rd_acc) rptr_d = rptr_q + ONE;

    case (state_q)
      IDLE: begin
        if (store_rx_data)      state_d = RX;
        else if (store_tx_data) state_d = TX;
      end
      TX, RX: begin
        if (rd_acc && !wr_acc && occ == ONE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear/flush overrides everything decided above.
    if (kill) begin
      state_d = IDLE;
      wptr_d  = '0;
      rptr_d  = '0;
      wr_acc  = 1'b0;
      rd_acc  = 1'b0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      dir_d   = 1'b0;
    end

    occ_d = wptr_d - rptr_d;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q          <= IDLE;
      wptr_q           <= '0;
      rptr_q           <= '0;
      wr_en            <= 1'b0;
      rd_en            <= 1'b0;
      wr_addr          <= '0;
      rd_addr          <= '0;
      buffer_occupancy <= '0;
      overflow         <= 1'b0;
      underflow        <= 1'b0;
      dir_err          <= 1'b0;
    end else begin
      state_q          <= state_d;
      wptr_q           <= wptr_d;
      rptr_q           <= rptr_d;
      wr_en            <= wr_acc;
      rd_en            <= rd_acc;
      wr_addr          <= kill ? '0 : wptr_q[AW-1:0];
      rd_addr          <= kill ? '0 : rptr_q[AW-1:0];
      buffer_occupancy <= occ_d;
      overflow         <= ovf_d;
      underflow        <= unf_d;
      dir_err          <= dir_d;
    end
  end

  assign mode = state_q;

endmodule

// File: doc/db_arbiter.md
# db_arbiter

Controller and arbiter for the 64-byte USB data buffer. Owns the write and read pointers, the buffer occupancy and the buffer direction. Shares the single buffer between four requesters: AHB-side store and get, RX-decoder store, and TX-encoder get. Sits between the AHB slave, the RX/TX protocol blocks and the buffer storage array, and issues registered one-cycle write and read strobes with addresses.

## Interface
Parameters:
- DEPTH, 64, buffer entries; power of two.
- AW, 6, address width, log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- n_rst  in  1  reset, synchronous, active-low.
- store_tx_data  in  1  AHB write-request pulse, one entry (TX direction).
- store_rx_data  in  1  RX decoder write-request pulse, one entry (RX direction).
- get_tx_data  in  1  TX encoder read-request pulse (TX direction).
- get_rx_data  in  1  AHB read-request pulse (RX direction).
- clear  in  1  AHB buffer clear.
- flush  in  1  RX error flush.
- wr_en  out  1  storage write strobe.
- wr_addr  out  AW  storage write address.
- rd_en  out  1  storage read strobe.
- rd_addr  out  AW  storage read address.
- buffer_occupancy  out  AW+1  entries held, 0..DEPTH.
- mode  out  2  buffer direction: 0 IDLE, 1 TX, 2 RX.
- overflow  out  1  one-cycle pulse: write dropped because the buffer is full.
- underflow  out  1  one-cycle pulse: read dropped because the buffer is empty.
- dir_err  out  1  one-cycle pulse: request dropped because it is the wrong direction for the current mode.

## Operation
- Internal pointers wptr and rptr are AW+1 bits wide. The MSB is the wrap bit.
- wr_addr = wptr[AW-1:0] and rd_addr = rptr[AW-1:0], registered.
- buffer_occupancy = wptr - rptr, modulo 2^(AW+1). It is a registered output.
- Full means occupancy == DEPTH. Empty means occupancy == 0.
- Mode FSM states:
  - IDLE:
    - store_rx_data: accept the write, go to RX.
    - store_tx_data alone: accept the write, go to TX.
    - Both stores in the same cycle: RX wins. store_tx_data is dropped and dir_err pulses.
    - Either get in IDLE: underflow pulses.
  - TX:
    - Legal requests are store_tx_data and get_tx_data.
    - store_rx_data or get_rx_data: dir_err pulses and the request is ignored.
  - RX:
    - Legal requests are store_rx_data and get_rx_data.
    - Either TX request: dir_err pulses and the request is ignored.
  - TX or RX to IDLE: an accepted read leaves next occupancy 0 with no accepted write in the same cycle.
- Accepted write (legal direction, not full):
  - wr_en = 1 next cycle, with wr_addr = the pre-increment wptr.
  - wptr increments.
- Accepted read (legal direction, not empty):
  - rd_en = 1 next cycle, with rd_addr = the pre-increment rptr.
  - rptr increments.
- Legal write and legal read in the same cycle:
  - Both are accepted and occupancy is unchanged.
  - When full, the write is still dropped (overflow pulses) and the read is accepted.
  - When empty, the read is dropped (underflow pulses) and the write is accepted.
- Write while full: dropped, overflow pulses, no wr_en. Read while empty: dropped, underflow pulses, no rd_en.
- clear or flush has highest priority in any state. Next cycle:
  - wptr = rptr = 0, occupancy 0, mode IDLE.
  - wr_en = rd_en = 0; all error pulses 0.
  - Requests in that cycle are discarded.
- Pointers wrap naturally: the address goes DEPTH-1 → 0 and the wrap bit toggles.

## Timing
- Reset: sampled at the clock edge while n_rst = 0.
  - All outputs, wptr and rptr are 0; mode is IDLE.
  - Reset asserted mid-transfer discards all state; no strobe follows.
- Latency: request at edge N produces strobe, address, updated occupancy, mode and error pulses valid after edge N+1.
- No stall or ready handshake exists. Requesters issue at most one request per signal per cycle, and any request may be back-to-back.
- wr_en, rd_en, overflow, underflow and dir_err are strictly single-cycle per request.

## Test plan
- Reset then IDLE: n_rst low 2 cycles with store_tx_data high → after release, all outputs 0, mode 0; the first store_tx_data → wr_en with wr_addr 0, occupancy 1, mode 1.
- TX fill/drain: 64 store_tx_data → occupancy 64; 65th → overflow, no wr_en. Then 64 get_tx_data → rd_addr 0..63, occupancy 0, mode 0; 65th get → underflow.
- Wrap: in RX mode, 40 writes, 40 reads, then 40 writes → wr_addr sequence 63→0 and occupancy 40. Then simultaneous store_rx_data and get_rx_data → both strobes, occupancy stays 40.
- Direction errors: in RX mode with occupancy 5, get_tx_data → dir_err, no rd_en, occupancy 5. In IDLE, store_tx_data and store_rx_data together → mode 2, dir_err, occupancy 1.
- Flush mid-packet: RX mode with occupancy 10, flush together with store_rx_data → next cycle occupancy 0, mode 0, no wr_en; the next store_tx_data writes address 0.
- Full plus simultaneous: TX mode with occupancy 64, store_tx_data and get_tx_data together → overflow, rd_en, occupancy 63.
